// File: rtl/cla_pkg.sv
// cla_pkg: shared width, P/G bundle type and carry-in constants for the CLA adder/subtractor pipelines.
package cla_pkg;

    localparam int CLA_WIDTH = 6;

    typedef struct packed {
        logic [CLA_WIDTH-1:0] p;
        logic [CLA_WIDTH-1:0] g;
    } pg_t;

    // Subtraction is A + ~B + 1, so the lookahead is seeded with a forced carry-in.
    localparam logic SUB_CIN = 1'b1;
    localparam logic ADD_CIN = 1'b0;

endpackage

// File: rtl/cla_carry_unit.sv
// cla_carry_unit: flattened carry-lookahead network producing C[WIDTH:1] from per-bit P/G and carry-in.
module cla_carry_unit #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0] g_i,
    input  logic             cin_i,
    output logic [WIDTH:1]   c_o
);

    // Each carry is an independent sum-of-products over G/P/cin; no carry feeds another.
    always_comb begin
        logic sop;
        logic prod;
        c_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            prod = cin_i;
            for (int k = 0; k <= i; k++) prod = prod & p_i[k];
            sop = prod;
            for (int j = 0; j <= i; j++) begin
                prod = g_i[j];
                for (int k = j + 1; k <= i; k++) prod = prod & p_i[k];
                sop = sop | prod;
            end
            c_o[i+1] = sop;
        end
    end

endmodule

// File: rtl/cla_subtractor_6bit_pipe.sv
// cla_subtractor_6bit_pipe: two-stage valid/ready pipelined carry-lookahead subtractor (A - B, borrow).
module cla_subtractor_6bit_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH:1]   carry;
    logic             accept;
    logic             s2_adv;

    cla_carry_unit #(.WIDTH(WIDTH)) u_carry (
        .p_i   (p_q),
        .g_i   (g_q),
        .cin_i (SUB_CIN),
        .c_o   (carry)
    );

    // o_ready depends only on state and i_ready, never on i_valid.
    always_comb begin
        s2_adv      = s1_valid_q & (~out_valid_q | i_ready);
        o_ready     = ~s1_valid_q | s2_adv;
        accept      = i_valid & o_ready;
        s1_valid_d  = accept | (s1_valid_q & ~s2_adv);
        p_d         = accept ? (i_minuend ^ ~i_subtrahend) : p_q;
        g_d         = accept ? (i_minuend & ~i_subtrahend) : g_q;
        out_valid_d = s2_adv | (out_valid_q & ~i_ready);
        diff_d      = s2_adv ? (p_q ^ {carry[WIDTH-1:1], SUB_CIN}) : diff_q;
        borrow_d    = s2_adv ? ~carry[WIDTH] : borrow_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q  <= 1'b0;
            p_q         <= '0;
            g_q         <= '0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            p_q         <= p_d;
            g_q         <= g_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
        end
    end

    assign o_valid  = out_valid_q;
    assign o_diff   = diff_q;
    assign o_borrow = borrow_q;

endmodule

// File: tb/tb_cla_subtractor_6bit_pipe.sv
// tb_cla_subtractor_6bit_pipe: directed scenario bench for the pipelined CLA subtractor.
module tb_cla_subtractor_6bit_pipe;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [5:0] i_minuend;
    logic [5:0] i_subtrahend;
    logic       o_valid;
    logic       i_ready;
    logic [5:0] o_diff;
    logic       o_borrow;

    int checks   = 0;
    int failures = 0;

    cla_subtractor_6bit_pipe dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_minuend    (i_minuend),
        .i_subtrahend (i_subtrahend),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_diff       (o_diff),
        .o_borrow     (o_borrow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_minuend = '0;
        i_subtrahend = '0;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++;
        if (o_diff !== 6'd0) begin failures++; $display("FAIL reset_diff got=%0d exp=0", o_diff); end
        checks++;
        if (o_borrow !== 1'b0) begin failures++; $display("FAIL reset_borrow got=%b exp=0", o_borrow); end
        i_rst_n = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    endtask

    task automatic test_single(input string name, input logic [5:0] a, input logic [5:0] b,
                               input logic [5:0] exp_d, input logic exp_b);
        @(negedge i_clk);
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_minuend = a;
        i_subtrahend = b;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL %s_ready got=%b exp=1", name, o_ready); end
        @(negedge i_clk);
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL %s_early_valid got=%b exp=0", name, o_valid); end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1) begin failures++; $display("FAIL %s_valid got=%b exp=1", name, o_valid); end
        checks++;
        if (o_diff !== exp_d) begin failures++; $display("FAIL %s_diff got=%0d exp=%0d", name, o_diff, exp_d); end
        checks++;
        if (o_borrow !== exp_b) begin failures++; $display("FAIL %s_borrow got=%b exp=%b", name, o_borrow, exp_b); end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL %s_drain got=%b exp=0", name, o_valid); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] av [64];
        logic [5:0] bv [64];
        logic [5:0] exp_d;
        logic       exp_b;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        for (int i = 0; i < 64; i++) begin
            av[i] = 6'($urandom_range(0, 63));
            bv[i] = 6'($urandom_range(0, 63));
        end
        @(negedge i_clk);
        i_ready = 1'b1;
        while (got < 64 && cyc < 300) begin
            cyc++;
            if (o_valid === 1'b1) begin
                exp_d = 6'(av[got] - bv[got]);
                exp_b = (av[got] < bv[got]);
                checks++;
                if (o_diff !== exp_d || o_borrow !== exp_b) begin
                    failures++;
                    $display("FAIL stream_%0d got=%0d/%b exp=%0d/%b", got, o_diff, o_borrow, exp_d, exp_b);
                end
                got++;
            end
            if (sent < 64) begin
                i_valid = 1'b1;
                i_minuend = av[sent];
                i_subtrahend = bv[sent];
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (i_valid) begin
                checks++;
                if (o_ready !== 1'b1) begin failures++; $display("FAIL stream_ready got=%b exp=1", o_ready); end
                if (o_ready === 1'b1) sent++;
            end
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        checks++;
        if (got != 64) begin failures++; $display("FAIL stream_count got=%0d exp=64", got); end
        checks++;
        if (cyc != 66) begin failures++; $display("FAIL stream_cycles got=%0d exp=66", cyc); end
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL stream_extra got=%b exp=0", o_valid); end
    endtask

    task automatic test_backpressure();
        @(negedge i_clk);
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_minuend = 6'd10;
        i_subtrahend = 6'd3;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL bp_ready0 got=%b exp=1", o_ready); end
        @(negedge i_clk);
        i_minuend = 6'd3;
        i_subtrahend = 6'd10;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", o_ready); end
        @(negedge i_clk);
        i_minuend = 6'd20;
        i_subtrahend = 6'd20;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", o_ready); end
        checks++;
        if (o_valid !== 1'b1 || o_diff !== 6'd7 || o_borrow !== 1'b0) begin
            failures++; $display("FAIL bp_first got=%b/%0d/%b exp=1/7/0", o_valid, o_diff, o_borrow);
        end
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b0) begin failures++; $display("FAIL bp_still_full got=%b exp=0", o_ready); end
        checks++;
        if (o_valid !== 1'b1 || o_diff !== 6'd7 || o_borrow !== 1'b0) begin
            failures++; $display("FAIL bp_hold got=%b/%0d/%b exp=1/7/0", o_valid, o_diff, o_borrow);
        end
        i_ready = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", o_ready); end
        @(negedge i_clk);
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_diff !== 6'd57 || o_borrow !== 1'b1) begin
            failures++; $display("FAIL bp_second got=%b/%0d/%b exp=1/57/1", o_valid, o_diff, o_borrow);
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_diff !== 6'd0 || o_borrow !== 1'b0) begin
            failures++; $display("FAIL bp_third got=%b/%0d/%b exp=1/0/0", o_valid, o_diff, o_borrow);
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", o_valid); end
    endtask

    task automatic test_bubble();
        @(negedge i_clk);
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_minuend = 6'd50;
        i_subtrahend = 6'd7;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_diff !== 6'd43 || o_borrow !== 1'b0) begin
            failures++; $display("FAIL bubble_fill got=%b/%0d/%b exp=1/43/0", o_valid, o_diff, o_borrow);
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_diff !== 6'd43) begin
            failures++; $display("FAIL bubble_hold got=%b/%0d exp=1/43", o_valid, o_diff);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL bubble_drop got=%b exp=0", o_valid); end
        i_ready = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL bubble_dup got=%b exp=0", o_valid); end
    endtask

    task automatic test_reset_midflight();
        @(negedge i_clk);
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_minuend = 6'd9;
        i_subtrahend = 6'd4;
        @(negedge i_clk);
        i_minuend = 6'd1;
        i_subtrahend = 6'd2;
        @(negedge i_clk);
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_diff !== 6'd5) begin
            failures++; $display("FAIL rst_pre got=%b/%0d exp=1/5", o_valid, o_diff);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_diff !== 6'd0 || o_borrow !== 1'b0) begin
            failures++; $display("FAIL rst_async got=%b/%0d/%b exp=0/0/0", o_valid, o_diff, o_borrow);
        end
        checks++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", o_ready); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            checks++;
            if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_stale_%0d got=%b exp=0", i, o_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single("basic", 6'd45, 6'd17, 6'd28, 1'b0);
        test_single("wrap0m1", 6'd0, 6'd1, 6'd63, 1'b1);
        test_single("eq63", 6'd63, 6'd63, 6'd0, 1'b0);
        test_single("m32m33", 6'd32, 6'd33, 6'd63, 1'b1);
        test_single("m5m40", 6'd5, 6'd40, 6'd29, 1'b1);
        test_single("m40m5", 6'd40, 6'd5, 6'd35, 1'b0);
        test_back_to_back();
        test_backpressure();
        test_bubble();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_subtractor_6bit_pipe.md
# cla_subtractor_6bit_pipe

Pipelined 6-bit carry-lookahead subtractor, the inverse operation of the 6-bit carry-lookahead adder.
- Accepts operand pairs over a valid/ready handshake and computes minuend − subtrahend as A + ~B + 1.
- Returns the 6-bit difference and a borrow flag two cycles later, with full backpressure support.
- Used as the subtract-side companion in the adder test/classification datapath.

## Interface
- WIDTH, 6, operand width; legal range 2..16; all arithmetic rules below scale with WIDTH.
- i_clk  input  1  single clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  upstream operand pair valid.
- o_ready  output  1  block can accept the operand pair this cycle.
- i_minuend  input  WIDTH  operand A.
- i_subtrahend  input  WIDTH  operand B.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_diff  output  WIDTH  (A − B) mod 2^WIDTH.
- o_borrow  output  1  1 when A < B (unsigned), i.e. the inverted carry-out.

## Operation
- **Arithmetic:** B is inverted and the carry-in is forced to 1.
  - P[i] = A[i] ^ ~B[i], G[i] = A[i] & ~B[i].
  - C[0] = 1, C[i+1] = G[i] | P[i]&C[i].
  - All carries come from flattened lookahead (sum-of-products of G/P), never a ripple chain.
  - o_diff[i] = P[i] ^ C[i]; o_borrow = ~C[WIDTH].
- **Stage 1 (S1):** on acceptance (i_valid & o_ready), register P, G and s1_valid = 1.
- **Stage 2 (S2):** on S1 advance, register o_diff, o_borrow and o_valid = 1 from the lookahead of the S1 P/G.
- **Output hold:** S2 is the output register. o_diff/o_borrow are held stable while o_valid & ~i_ready.
- **Advance rules:**
  - s2_adv = s1_valid & (~o_valid | i_ready).
  - o_ready = ~s1_valid | s2_adv.
  - Combinational paths: i_ready → o_ready only. No path from i_valid to o_ready.
- **Bubble collapse:** an empty stage is filled even when the stage after it is stalled.
- **Valid bookkeeping when a stage empties:**
  - s1_valid clears when S1 advances without a new acceptance.
  - o_valid clears when i_ready is high and no S1 advance occurs.
- **Simultaneous events:** acceptance into S1 and S1→S2 advance in the same cycle are legal. Result: one transfer per cycle sustained.
- **Capacity:** 2 transactions in flight. When both stages are full and i_ready = 0, o_ready = 0.
- **No reordering, drop or duplication:** results leave in acceptance order.

## Timing
- **Reset (asynchronous assert):** s1_valid = 0, o_valid = 0, o_diff = 0, o_borrow = 0, P/G = 0.
  - o_ready reads 1 immediately after reset.
  - Reset mid-operation discards all in-flight transactions; no result appears after release.
- **Latency:** an operand accepted at edge N produces o_valid = 1 after edge N+1 when not stalled (visible in cycle N+1 → N+2 window).
  - Two register stages, zero combinational input→output paths.
- **Throughput:** 1 result/cycle with i_ready held high.
- **Stall:** while i_ready = 0, o_valid and the data stay constant. Up to 2 accepted pairs are buffered, then o_ready drops in the following cycle.
- **Critical path:** S1 P/G registers → lookahead carry → difference XOR → S2 registers.

## Structure
- **Package cla_pkg:**
  - CLA_WIDTH = 6.
  - typedef pg_t (struct of P and G vectors, CLA_WIDTH bits each).
  - Function/constant for the carry-in value of subtraction (1).
- **Sub-module cla_carry_unit:** purely combinational.
  - Inputs: pg_t, cin. Outputs: C[WIDTH:1].
  - Flattened lookahead equations.
  - Reusable by the adder-side pipeline with cin = 0.
- **Top module:** handshake control, S1/S2 registers, B inversion, final XOR.

## Test plan
- **Basic subtract:** after reset, A = 6'd45, B = 6'd17, i_ready = 1 → o_diff = 28, o_borrow = 0, exactly 2 cycles after acceptance.
- **Borrow/wrap:** A = 0, B = 1 → o_diff = 63, o_borrow = 1. A = 63, B = 63 → o_diff = 0, o_borrow = 0. A = 32, B = 33 → o_diff = 63, o_borrow = 1.
- **Back-to-back streaming:** 64 consecutive random pairs with i_valid = 1 and i_ready = 1 → o_ready stays 1, 64 results in order, each matching the reference model (A − B) mod 64 and A < B.
- **Backpressure:** i_ready = 0 while feeding 3 pairs → only 2 accepted, o_ready = 0 from the cycle after the 2nd acceptance, o_diff held constant. Raise i_ready → both results drain in order, then the 3rd is accepted.
- **Bubble collapse:** a single pair enters, then i_valid = 0 with i_ready toggling 0/1/0 → result held until i_ready = 1, o_valid drops the cycle after the transfer, no duplicate.
- **Async reset mid-flight:** two pairs in flight, assert i_rst_n = 0 between edges → o_valid = 0 and o_diff = 0 immediately; after release o_ready = 1 and no stale result ever appears.
